// File: rtl/vga_timing_pkg.sv
// Shared types and named timing sets for the parametrised VGA timing generator.
package vga_timing_pkg;

  // Scan controller states: IDLE holds counters at the origin, RUN scans.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // One complete timing set: segment lengths in pixel clocks / lines.
  typedef struct packed {
    int unsigned h_sync;
    int unsigned h_back;
    int unsigned h_disp;
    int unsigned h_front;
    int unsigned v_sync;
    int unsigned v_back;
    int unsigned v_disp;
    int unsigned v_front;
  } timing_set_t;

  localparam timing_set_t VGA_640x480 = '{
    h_sync: 96, h_back: 48,  h_disp: 640,  h_front: 16,
    v_sync: 2,  v_back: 33,  v_disp: 480,  v_front: 10
  };

  localparam timing_set_t HD_1280x720 = '{
    h_sync: 40, h_back: 220, h_disp: 1280, h_front: 110,
    v_sync: 5,  v_back: 20,  v_disp: 720,  v_front: 5
  };

  // Bit positions of the flags carried through the delay line.
  localparam int FLAG_W     = 5;
  localparam int FLAG_HS    = 4;
  localparam int FLAG_VS    = 3;
  localparam int FLAG_DE    = 2;
  localparam int FLAG_FRAME = 1;
  localparam int FLAG_LINE  = 0;

  // Total period of a line or frame from its four segments.
  function automatic int unsigned seg_total(int unsigned s, int unsigned b,
                                            int unsigned d, int unsigned f);
    return s + b + d + f;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Parametrised-depth shift register with a per-bit reset value; one bit of an
// intermediate stage is exposed so the caller can align side data with it.
module vga_delay_line #(
  parameter int             DEPTH     = 2,
  parameter int             W         = 5,
  parameter logic [W-1:0]   RST_VAL   = '0,
  parameter int             TAP_STAGE = 0,
  parameter int             TAP_BIT   = 0
) (
  input  logic         pixel_clk,
  input  logic         sys_rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         tap_bit
);

  logic [W-1:0] stage_reg [DEPTH];

  // Shift every stage by one each clock; reset loads the inactive pattern.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_reg[i] <= RST_VAL;
      end
    end else begin
      stage_reg[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign dout    = stage_reg[DEPTH-1];
  assign tap_bit = stage_reg[TAP_STAGE][TAP_BIT];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA/HD timing generator: h/v counters with a frame-boundary run/idle
// controller, registered pixel requests, and sync/DE/pulse outputs delayed to
// line up with pixel data returned REQ_LAT cycles after each request.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_SYNC  = VGA_640x480.h_sync,
  parameter int   H_BACK  = VGA_640x480.h_back,
  parameter int   H_DISP  = VGA_640x480.h_disp,
  parameter int   H_FRONT = VGA_640x480.h_front,
  parameter int   V_SYNC  = VGA_640x480.v_sync,
  parameter int   V_BACK  = VGA_640x480.v_back,
  parameter int   V_DISP  = VGA_640x480.v_disp,
  parameter int   V_FRONT = VGA_640x480.v_front,
  parameter logic HS_POL  = 1'b0,
  parameter logic VS_POL  = 1'b0,
  parameter int   RGB_W   = 6,
  parameter int   REQ_LAT = 1,
  parameter int   CNT_W   = 11
) (
  input  logic             pixel_clk,
  input  logic             sys_rst_n,
  input  logic             timing_en,
  input  logic [RGB_W-1:0] pixel_data,
  output logic             pixel_req,
  output logic [CNT_W-1:0] pixel_xpos,
  output logic [CNT_W-1:0] pixel_ypos,
  output logic             video_hs,
  output logic             video_vs,
  output logic             video_de,
  output logic [RGB_W-1:0] video_rgb,
  output logic             frame_start,
  output logic             line_start
);

  localparam int unsigned H_TOTAL = seg_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
  localparam int unsigned V_TOTAL = seg_total(V_SYNC, V_BACK, V_DISP, V_FRONT);
  localparam int unsigned HA      = H_SYNC + H_BACK;
  localparam int unsigned VA      = V_SYNC + V_BACK;
  localparam int unsigned HE      = HA + H_DISP;
  localparam int unsigned VE      = VA + V_DISP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // Flag pattern that means "nothing happening": syncs inactive, no DE/pulses.
  localparam logic [FLAG_W-1:0] FLAG_IDLE = {~HS_POL, ~VS_POL, 3'b000};

  generate
    if (((64'd1 << CNT_W) < 64'(H_TOTAL)) || ((64'd1 << CNT_W) < 64'(V_TOTAL))) begin : g_cnt_w_check
      $error("vga_timing_gen: CNT_W=%0d too narrow for H_TOTAL=%0d / V_TOTAL=%0d",
             CNT_W, H_TOTAL, V_TOTAL);
    end
    if ((REQ_LAT < 1) || (REQ_LAT > 4)) begin : g_lat_check
      $error("vga_timing_gen: REQ_LAT=%0d outside 1..4", REQ_LAT);
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_h_reg, cnt_h_next;
  logic [CNT_W-1:0] cnt_v_reg, cnt_v_next;

  logic [31:0]       h_pos, v_pos;
  logic              run, hs_act, vs_act, de_raw, frame_raw, line_raw;
  logic [CNT_W-1:0]  xpos_next, ypos_next;
  logic [FLAG_W-1:0] flag_next, flag_reg, flag_out;
  logic              de_at_data;
  logic [RGB_W-1:0]  rgb_reg;

  assign h_pos = 32'(cnt_h_reg);
  assign v_pos = 32'(cnt_v_reg);

  // Controller and counter registers.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg <= IDLE;
      cnt_h_reg <= '0;
      cnt_v_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_h_reg <= cnt_h_next;
      cnt_v_reg <= cnt_v_next;
    end
  end

  // Next state / counters; leaving RUN is only possible on the last frame cycle.
  always_comb begin
    state_next = state_reg;
    cnt_h_next = cnt_h_reg;
    cnt_v_next = cnt_v_reg;
    case (state_reg)
      IDLE: begin
        cnt_h_next = '0;
        cnt_v_next = '0;
        if (timing_en) state_next = RUN;
      end
      RUN: begin
        if (cnt_h_reg == H_LAST) begin
          cnt_h_next = '0;
          if (cnt_v_reg == V_LAST) begin
            cnt_v_next = '0;
            if (!timing_en) state_next = IDLE;
          end else begin
            cnt_v_next = cnt_v_reg + CNT_W'(1);
          end
        end else begin
          cnt_h_next = cnt_h_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_h_next = '0;
        cnt_v_next = '0;
      end
    endcase
  end

  // Decode the counter position into raw sync/active/pulse flags.
  always_comb begin
    run       = (state_reg == RUN);
    hs_act    = run && (h_pos < H_SYNC);
    vs_act    = run && (v_pos < V_SYNC);
    de_raw    = run && (h_pos >= HA) && (h_pos < HE) && (v_pos >= VA) && (v_pos < VE);
    frame_raw = run && (h_pos == 0) && (v_pos == 0);
    line_raw  = run && (h_pos == 0);
    xpos_next = de_raw ? CNT_W'(h_pos - HA) : '0;
    ypos_next = de_raw ? CNT_W'(v_pos - VA) : '0;
    flag_next = {hs_act ? HS_POL : ~HS_POL,
                 vs_act ? VS_POL : ~VS_POL,
                 de_raw, frame_raw, line_raw};
  end

  // Request outputs and the flag stage that feeds the delay line, in lockstep.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pixel_req  <= 1'b0;
      pixel_xpos <= '0;
      pixel_ypos <= '0;
      flag_reg   <= FLAG_IDLE;
    end else begin
      pixel_req  <= de_raw;
      pixel_xpos <= xpos_next;
      pixel_ypos <= ypos_next;
      flag_reg   <= flag_next;
    end
  end

  // REQ_LAT+1 stages after the request; the DE tap one stage early lines up
  // with the returning pixel_data so the colour register lands with video_de.
  vga_delay_line #(
    .DEPTH     (REQ_LAT + 1),
    .W         (FLAG_W),
    .RST_VAL   (FLAG_IDLE),
    .TAP_STAGE (REQ_LAT - 1),
    .TAP_BIT   (FLAG_DE)
  ) u_delay (
    .pixel_clk (pixel_clk),
    .sys_rst_n (sys_rst_n),
    .din       (flag_reg),
    .dout      (flag_out),
    .tap_bit   (de_at_data)
  );

  // Colour register: blanked to zero whenever the aligned DE is low.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rgb_reg <= '0;
    end else begin
      rgb_reg <= de_at_data ? pixel_data : '0;
    end
  end

  assign video_hs    = flag_out[FLAG_HS];
  assign video_vs    = flag_out[FLAG_VS];
  assign video_de    = flag_out[FLAG_DE];
  assign frame_start = flag_out[FLAG_FRAME];
  assign line_start  = flag_out[FLAG_LINE];
  assign video_rgb   = rgb_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a miniature timing set (17x9 clocks per frame):
// dut_a uses REQ_LAT=1 with active-low syncs, dut_b REQ_LAT=3 with active-high.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int CW    = 5;
  localparam int RW    = 6;
  localparam int FRAME = 153;   // 17 * 9

  typedef struct packed {
    logic          req;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          hs;
    logic          vs;
    logic          de;
    logic [RW-1:0] rgb;
    logic          fs;
    logic          ls;
  } obs_t;

  typedef struct {
    int   k;
    obs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_a = 1'b0;
  logic en_b = 1'b0;

  logic          req_a, hs_a, vs_a, de_a, fs_a, ls_a;
  logic [CW-1:0] x_a, y_a;
  logic [RW-1:0] rgb_a, pd_a;
  logic          req_b, hs_b, vs_b, de_b, fs_b, ls_b;
  logic [CW-1:0] x_b, y_b;
  logic [RW-1:0] rgb_b, pd_b;
  logic [RW-1:0] pipe_a;
  logic [RW-1:0] pipe_b [3];
  obs_t obs_a, obs_b;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_SYNC(4), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(2), .V_DISP(4), .V_FRONT(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .RGB_W(RW), .REQ_LAT(1), .CNT_W(CW)
  ) dut_a (
    .pixel_clk(clk), .sys_rst_n(rst_n), .timing_en(en_a), .pixel_data(pd_a),
    .pixel_req(req_a), .pixel_xpos(x_a), .pixel_ypos(y_a),
    .video_hs(hs_a), .video_vs(vs_a), .video_de(de_a), .video_rgb(rgb_a),
    .frame_start(fs_a), .line_start(ls_a)
  );

  vga_timing_gen #(
    .H_SYNC(4), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(2), .V_DISP(4), .V_FRONT(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .RGB_W(RW), .REQ_LAT(3), .CNT_W(CW)
  ) dut_b (
    .pixel_clk(clk), .sys_rst_n(rst_n), .timing_en(en_b), .pixel_data(pd_b),
    .pixel_req(req_b), .pixel_xpos(x_b), .pixel_ypos(y_b),
    .video_hs(hs_b), .video_vs(vs_b), .video_de(de_b), .video_rgb(rgb_b),
    .frame_start(fs_b), .line_start(ls_b)
  );

  // Pixel source models: return xpos as colour REQ_LAT cycles after the request.
  always_ff @(posedge clk) begin
    pipe_a    <= RW'(x_a);
    pipe_b[0] <= RW'(x_b);
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign pd_a = pipe_a;
  assign pd_b = pipe_b[2];

  assign obs_a = {req_a, x_a, y_a, hs_a, vs_a, de_a, rgb_a, fs_a, ls_a};
  assign obs_b = {req_b, x_b, y_b, hs_b, vs_b, de_b, rgb_b, fs_b, ls_b};

  function automatic vec_t mk(int k, logic req, int x, int y, logic hs, logic vs,
                              logic de, int rgb, logic fs, logic ls);
    vec_t v;
    v.k       = k;
    v.exp.req = req;
    v.exp.x   = CW'(x);
    v.exp.y   = CW'(y);
    v.exp.hs  = hs;
    v.exp.vs  = vs;
    v.exp.de  = de;
    v.exp.rgb = RW'(rgb);
    v.exp.fs  = fs;
    v.exp.ls  = ls;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got req=%0b x=%0d y=%0d hs=%0b vs=%0b de=%0b rgb=%0d fs=%0b ls=%0b, need req=%0b x=%0d y=%0d hs=%0b vs=%0b de=%0b rgb=%0d fs=%0b ls=%0b",
               name, act.req, act.x, act.y, act.hs, act.vs, act.de, act.rgb, act.fs, act.ls,
               exp.req, exp.x, exp.y, exp.hs, exp.vs, exp.de, exp.rgb, exp.fs, exp.ls);
    end else begin
      $display("ok   %s", name);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, need %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic wait_fs_a(input int budget, output int found);
    found = 0;
    for (int i = 0; i < budget; i++) begin
      if (fs_a) begin
        found = 1;
        break;
      end
      step();
    end
  endtask

  vec_t vec_a[$];
  vec_t vec_b[$];
  obs_t idle_a, idle_b;
  int found, n;
  int c_hs, c_vs, c_de, c_fs, c_ls, c_req, c_rgb_bad, x_max, y_max, c_hs_b, c_vs_b, c_de_b;

  initial begin
    // dut_a: outputs at cycle k show counter index p=k-3, requests p=k-1.
    vec_a.push_back(mk(  0, 0,0,0, 1,1,0,0, 0,0));
    vec_a.push_back(mk(  1, 0,0,0, 1,1,0,0, 0,0));
    vec_a.push_back(mk(  3, 0,0,0, 0,0,0,0, 1,1));
    vec_a.push_back(mk(  4, 0,0,0, 0,0,0,0, 0,0));
    vec_a.push_back(mk(  7, 0,0,0, 1,0,0,0, 0,0));
    vec_a.push_back(mk( 20, 0,0,0, 0,0,0,0, 0,1));
    vec_a.push_back(mk( 37, 0,0,0, 0,1,0,0, 0,1));
    vec_a.push_back(mk( 76, 1,0,0, 1,1,0,0, 0,0));
    vec_a.push_back(mk( 78, 1,2,0, 1,1,1,0, 0,0));
    vec_a.push_back(mk( 80, 1,4,0, 1,1,1,2, 0,0));
    vec_a.push_back(mk( 83, 1,7,0, 1,1,1,5, 0,0));
    vec_a.push_back(mk( 85, 0,0,0, 1,1,1,7, 0,0));
    vec_a.push_back(mk( 86, 0,0,0, 1,1,0,0, 0,0));
    vec_a.push_back(mk( 88, 0,0,0, 0,1,0,0, 0,1));
    vec_a.push_back(mk(110, 1,0,2, 1,1,0,0, 0,0));
    vec_a.push_back(mk(134, 1,7,3, 1,1,1,5, 0,0));
    vec_a.push_back(mk(136, 0,0,0, 1,1,1,7, 0,0));
    vec_a.push_back(mk(137, 0,0,0, 1,1,0,0, 0,0));
    vec_a.push_back(mk(139, 0,0,0, 0,1,0,0, 0,1));
    vec_a.push_back(mk(156, 0,0,0, 0,0,0,0, 1,1));
    vec_a.push_back(mk(157, 0,0,0, 0,0,0,0, 0,0));
    // dut_b: outputs show p=k-5, active-high syncs.
    vec_b.push_back(mk(  0, 0,0,0, 0,0,0,0, 0,0));
    vec_b.push_back(mk(  5, 0,0,0, 1,1,0,0, 1,1));
    vec_b.push_back(mk(  9, 0,0,0, 0,1,0,0, 0,0));
    vec_b.push_back(mk( 39, 0,0,0, 1,0,0,0, 0,1));
    vec_b.push_back(mk( 80, 1,4,0, 0,0,1,0, 0,0));
    vec_b.push_back(mk( 87, 0,0,0, 0,0,1,7, 0,0));
    vec_b.push_back(mk( 88, 0,0,0, 0,0,0,0, 0,0));
    vec_b.push_back(mk(158, 0,0,0, 1,1,0,0, 1,1));
    idle_a = mk(0, 0,0,0, 1,1,0,0, 0,0).exp;
    idle_b = mk(0, 0,0,0, 0,0,0,0, 0,0).exp;

    // Reset and idle levels.
    rst_n = 1'b0;
    repeat (3) step();
    check_obs("reset_a", obs_a, idle_a);
    check_obs("reset_b", obs_b, idle_b);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) step();
    check_obs("idle_a", obs_a, idle_a);
    check_obs("idle_b", obs_b, idle_b);

    // Start both and apply the vector tables.
    @(negedge clk) begin en_a = 1'b1; en_b = 1'b1; end
    step();
    for (int k = 0; k <= 160; k++) begin
      foreach (vec_a[i]) if (vec_a[i].k == k) check_obs($sformatf("vecA k=%0d", k), obs_a, vec_a[i].exp);
      foreach (vec_b[i]) if (vec_b[i].k == k) check_obs($sformatf("vecB k=%0d", k), obs_b, vec_b[i].exp);
      step();
    end

    // One whole frame of statistics, starting on a frame_start sample.
    wait_fs_a(2 * FRAME, found);
    check_val("stats fs found", found, 1);
    c_hs = 0; c_vs = 0; c_de = 0; c_fs = 0; c_ls = 0; c_req = 0; c_rgb_bad = 0;
    x_max = 0; y_max = 0; c_hs_b = 0; c_vs_b = 0; c_de_b = 0;
    for (int i = 0; i < FRAME; i++) begin
      c_hs += (hs_a == 1'b0) ? 1 : 0;
      c_vs += (vs_a == 1'b0) ? 1 : 0;
      c_de += de_a ? 1 : 0;
      c_fs += fs_a ? 1 : 0;
      c_ls += ls_a ? 1 : 0;
      c_req += req_a ? 1 : 0;
      if (!de_a && rgb_a != '0) c_rgb_bad++;
      if (req_a && int'(x_a) > x_max) x_max = int'(x_a);
      if (req_a && int'(y_a) > y_max) y_max = int'(y_a);
      c_hs_b += (hs_b == 1'b1) ? 1 : 0;
      c_vs_b += (vs_b == 1'b1) ? 1 : 0;
      c_de_b += de_b ? 1 : 0;
      step();
    end
    check_val("a hs low cycles", c_hs, 36);
    check_val("a vs low cycles", c_vs, 34);
    check_val("a de cycles", c_de, 32);
    check_val("a req cycles", c_req, 32);
    check_val("a frame_start count", c_fs, 1);
    check_val("a line_start count", c_ls, 9);
    check_val("a rgb outside de", c_rgb_bad, 0);
    check_val("a xpos max", x_max, 7);
    check_val("a ypos max", y_max, 3);
    check_val("b hs high cycles", c_hs_b, 36);
    check_val("b vs high cycles", c_vs_b, 34);
    check_val("b de cycles", c_de_b, 32);
    check_val("a frame period fs", int'(fs_a), 1);

    // timing_en dropped and re-raised inside a frame: no gap, no truncation.
    n = 0;
    repeat (40) step();
    en_a = 1'b0;
    repeat (40) step();
    en_a = 1'b1;
    n = 80;
    while (!fs_a && n < 2 * FRAME) begin
      step();
      n++;
    end
    check_val("en blip frame period", n, FRAME);

    // timing_en dropped mid-frame and held low: frame finishes, then idle.
    wait_fs_a(2 * FRAME, found);
    check_val("drop fs found", found, 1);
    c_de = 0; c_fs = 0; c_ls = 0;
    for (int i = 0; i < 2 * FRAME + 10; i++) begin
      if (i == 90) en_a = 1'b0;
      c_de += de_a ? 1 : 0;
      c_fs += fs_a ? 1 : 0;
      c_ls += ls_a ? 1 : 0;
      step();
    end
    check_val("drop de cycles", c_de, 32);
    check_val("drop frame_start count", c_fs, 1);
    check_val("drop line_start count", c_ls, 9);
    check_obs("drop idle_a", obs_a, idle_a);

    // Restart from IDLE: frame_start three cycles after the sampling edge.
    @(negedge clk) en_a = 1'b1;
    step();
    c_fs = 0;
    for (int k = 0; k < 3; k++) begin
      c_fs += fs_a ? 1 : 0;
      step();
    end
    check_val("restart early fs", c_fs, 0);
    check_obs("restart k=3", obs_a, mk(3, 0,0,0, 0,0,0,0, 1,1).exp);

    // Asynchronous reset in the middle of an active line.
    n = 0;
    while (!de_a && n < 2 * FRAME) begin
      step();
      n++;
    end
    check_val("active line reached", int'(de_a), 1);
    #2 rst_n = 1'b0;
    #1;
    check_obs("async reset a", obs_a, idle_a);
    check_obs("async reset b", obs_b, idle_b);
    @(negedge clk) rst_n = 1'b1;
    step();
    repeat (3) step();
    check_obs("post reset a k=3", obs_a, mk(3, 0,0,0, 0,0,0,0, 1,1).exp);
    repeat (2) step();
    check_obs("post reset b k=5", obs_b, mk(5, 0,0,0, 1,1,0,0, 1,1).exp);
    repeat (73) step();
    check_obs("post reset a k=78", obs_a, mk(78, 1,2,0, 1,1,1,0, 0,0).exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised successor of the fixed 640x480 VGA driver: generates horizontal/vertical sync, data enable and pixel requests for any timing set, sync polarity and pixel-source latency. It sits between the pixel source (pattern generator, frame buffer reader) and the RGB pins. Every output is registered. A run/idle controller starts and stops scanning only on frame boundaries.

## Interface
- H_SYNC, 96: hsync width, pixel clocks
- H_BACK, 48: horizontal back porch
- H_DISP, 640: active pixels per line
- H_FRONT, 16: horizontal front porch
- V_SYNC, 2: vsync width, lines
- V_BACK, 33: vertical back porch
- V_DISP, 480: active lines
- V_FRONT, 10: vertical front porch
- HS_POL, 0: active level of video_hs during sync
- VS_POL, 0: active level of video_vs during sync
- RGB_W, 6: colour width (RGB222 default)
- REQ_LAT, 1: cycles from pixel_req to valid pixel_data, legal range 1..4
- CNT_W, 11: counter/coordinate width; elaboration error if 2^CNT_W < H_TOTAL or < V_TOTAL
- pixel_clk  in  1  pixel clock
- sys_rst_n  in  1  reset; asynchronous, active-low
- timing_en  in  1  run request, sampled only in IDLE and at end of frame
- pixel_data  in  RGB_W  colour from source, REQ_LAT cycles after pixel_req
- pixel_req  out  1  pixel request
- pixel_xpos  out  CNT_W  0-based column of the request, 0 when pixel_req=0
- pixel_ypos  out  CNT_W  0-based row of the request, 0 when pixel_req=0
- video_hs  out  1  horizontal sync
- video_vs  out  1  vertical sync
- video_de  out  1  data enable
- video_rgb  out  RGB_W  colour, 0 when video_de=0
- frame_start  out  1  one-cycle pulse aligned with output position (0,0)
- line_start  out  1  one-cycle pulse aligned with output position (0,v), every line

## Operation
- Derived values: H_TOTAL = H_SYNC+H_BACK+H_DISP+H_FRONT (800), V_TOTAL = V_SYNC+V_BACK+V_DISP+V_FRONT (525), HA = H_SYNC+H_BACK, VA = V_SYNC+V_BACK.
- Segment order within a line and a frame: sync, back porch, active, front porch.
- cnt_h wraps from H_TOTAL-1 to 0. cnt_v advances when cnt_h wraps and wraps from V_TOTAL-1 to 0.
- State machine:
  - IDLE: counters held at 0; timing_en=1 moves to RUN.
  - RUN: counters advance every cycle.
  - At the last cycle of a frame, (H_TOTAL-1, V_TOTAL-1): timing_en=0 moves to IDLE; otherwise stay in RUN.
  - Deasserting timing_en mid-frame never truncates the frame.
- Request decode: pixel_req=1 while cnt_h∈[HA,HA+H_DISP) and cnt_v∈[VA,VA+V_DISP). In that window pixel_xpos=cnt_h-HA and pixel_ypos=cnt_v-VA.
- Delay line: raw hs/vs/de/frame/line flags pass through REQ_LAT+1 register stages, so outputs align with the returned pixel_data.
- video_rgb is registered: pixel_data when the delayed de is 1, else 0.
- Sync outputs: video_hs = HS_POL during sync, ~HS_POL otherwise; video_vs likewise with VS_POL.
- IDLE output levels: sync outputs inactive, de=0, req=0, rgb=0, no pulses. These appear after the delay line drains.

## Timing
- Reset values: pixel_req=0, pixel_xpos=0, pixel_ypos=0, video_de=0, video_rgb=0, frame_start=0, line_start=0, video_hs=~HS_POL, video_vs=~VS_POL, state=IDLE, counters=0, delay line cleared to inactive.
- Reset takes effect immediately, without a clock, including mid-line.
- Start-up: the edge that samples timing_en=1 in IDLE enters RUN. The following cycle has counters at (0,0).
- pixel_req, pixel_xpos and pixel_ypos are registered, one cycle after the counter state they describe.
- video_de, video_hs, video_vs, video_rgb, frame_start and line_start lag pixel_req by exactly REQ_LAT+1 cycles.
- Frame period: H_TOTAL*V_TOTAL cycles (420000 for defaults). Back-to-back frames have no gap.
- Restart after IDLE: at least one IDLE cycle separates frames.

## Structure
- Package vga_timing_pkg holds:
  - the state enum (IDLE, RUN);
  - named timing sets: VGA_640x480 (96/48/640/16, 2/33/480/10) and HD_1280x720 (40/220/1280/110, 5/20/720/5).
- Sub-module vga_delay_line: parametrised-depth shift register with async reset value per bit. It carries hs, vs, de, frame_start and line_start.

## Test plan
- Defaults, REQ_LAT=1, timing_en=1 → per line hs low 96 of 800 cycles; vs low for 2 lines of 525; 307200 de cycles per frame; frame_start period 420000.
- Source model returning pixel_data=xpos[5:0] after 1 cycle → video_de rises 2 cycles after pixel_req. First active rgb=0 and last=63 on every line; rgb=0 outside de.
- REQ_LAT=3, HS_POL=1, VS_POL=1 → hs high for 96 cycles, vs high for 2 lines; de lags pixel_req by 4; data still pixel-aligned.
- timing_en dropped at line 100 → frame completes to (799,524); outputs then idle, no further frame_start. Re-raise → frame_start pulse after one IDLE cycle plus REQ_LAT+2.
- sys_rst_n asserted mid-active-line without a clock edge → all outputs at reset values immediately. Release with timing_en=1 → normal frame from (0,0).
- HD_1280x720 set, CNT_W=11 → pixel_xpos max 1279, pixel_ypos max 719; frame period 1650*750 = 1237500 cycles.
